// File: rtl/level_pkg.sv
// Shared types and default constants for the level/lives sequencer.
package level_pkg;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      GRACE = 2'd1,
      OVER  = 2'd2
   } level_state_t;

   localparam int LVL_WRAP_COUNT    = 695;
   localparam int LVL_DEFAULT_LIVES = 3;

endpackage

// File: rtl/level_sequencer_if.sv
// Bundle between the object-motion/draw logic and the level sequencer.
// master drives the game-side inputs; slave is the sequencer itself.
interface level_sequencer_if #(
   parameter int NUM_LEVELS = 4,
   parameter int COUNT_W    = 11,
   parameter int LIVES      = 3
);
   logic [COUNT_W-1:0]           obj_count;
   logic                         hit;
   logic                         frame_tick;
   logic                         start;
   logic [NUM_LEVELS-1:0]        shapes;
   logic [$clog2(NUM_LEVELS)-1:0] level;
   logic [$clog2(LIVES+1)-1:0]   lives_left;
   logic                         level_up;
   logic                         game_over;

   modport master (
      output obj_count, hit, frame_tick, start,
      input  shapes, level, lives_left, level_up, game_over
   );

   modport slave (
      input  obj_count, hit, frame_tick, start,
      output shapes, level, lives_left, level_up, game_over
   );
endinterface

// File: rtl/count_wrap_detect.sv
// Rising-edge detector on the obstacle position counter: pass_o is high for
// the single cycle in which obj_count first equals WRAP_COUNT.
module count_wrap_detect #(
   parameter int COUNT_W    = 11,
   parameter int WRAP_COUNT = 695
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [COUNT_W-1:0] obj_count_i,
   output logic               pass_o
);

   logic [COUNT_W-1:0] prev_q;

   // previous-cycle copy of the position counter
   always_ff @(posedge clk) begin
      if (reset) prev_q <= '0;
      else       prev_q <= obj_count_i;
   end

   assign pass_o = (obj_count_i == COUNT_W'(WRAP_COUNT)) &&
                   (prev_q != COUNT_W'(WRAP_COUNT));

endmodule

// File: rtl/level_sequencer.sv
// Level/lives controller for the obstacle game. Counts obstacle passes,
// advances one-hot levels, and (with LEVEL_LIVES_EN defined) tracks lives
// with a post-hit grace window and a game-over state.
//
// state | meaning
// PLAY  | normal play, hits accepted
// GRACE | post-hit immunity, counts frame_tick down to 0
// OVER  | no lives left, waits for start
module level_sequencer
   import level_pkg::*;
#(
   parameter int NUM_LEVELS       = 4,
   parameter int COUNT_W          = 11,
   parameter int WRAP_COUNT       = LVL_WRAP_COUNT,
   parameter int PASSES_PER_LEVEL = 1,
   parameter int LIVES            = LVL_DEFAULT_LIVES,
   parameter int GRACE_FRAMES     = 60
) (
   input logic              clk,
   input logic              reset,
   level_sequencer_if.slave bus
);

   localparam int LVL_W = $clog2(NUM_LEVELS);
   localparam int PC_W  = (PASSES_PER_LEVEL > 1) ? $clog2(PASSES_PER_LEVEL) : 1;
   localparam int LIV_W = $clog2(LIVES+1);
   localparam int GR_W  = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES+1) : 1;

   level_state_t     state_q, state_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
   logic [LIV_W-1:0] lives_q, lives_d;
   logic [GR_W-1:0]  grace_q, grace_d;
   logic             level_up_q, level_up_d;

   logic             pass;
   logic [LVL_W-1:0] adv_level;
   logic [PC_W-1:0]  adv_cnt;
   logic             adv_up;
   logic [NUM_LEVELS-1:0] shapes_c;

   count_wrap_detect #(
      .COUNT_W    (COUNT_W),
      .WRAP_COUNT (WRAP_COUNT)
   ) u_wrap (
      .clk         (clk),
      .reset       (reset),
      .obj_count_i (bus.obj_count),
      .pass_o      (pass)
   );

   // effect of one counted pass on level/pass counter
   always_comb begin
      adv_cnt   = pass_cnt_q + PC_W'(1);
      adv_level = level_q;
      adv_up    = 1'b0;
      if (pass_cnt_q == PC_W'(PASSES_PER_LEVEL-1)) begin
         adv_cnt = '0;
         if (level_q < LVL_W'(NUM_LEVELS-1)) begin
            adv_level = level_q + LVL_W'(1);
            adv_up    = 1'b1;
         end
      end
   end

   // next-state logic; a hit in PLAY always beats a simultaneous pass
   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      pass_cnt_d = pass_cnt_q;
      lives_d    = lives_q;
      grace_d    = grace_q;
      level_up_d = 1'b0;
`ifdef LEVEL_LIVES_EN
      case (state_q)
         PLAY: begin
            if (bus.hit) begin
               pass_cnt_d = '0;
               lives_d    = lives_q - LIV_W'(1);
               if (lives_q == LIV_W'(1)) begin
                  state_d = OVER;
               end else if (GRACE_FRAMES > 0) begin
                  state_d = GRACE;
                  grace_d = GR_W'(GRACE_FRAMES);
               end
            end else if (pass) begin
               level_d    = adv_level;
               pass_cnt_d = adv_cnt;
               level_up_d = adv_up;
            end
         end
         GRACE: begin
            if (pass) begin
               level_d    = adv_level;
               pass_cnt_d = adv_cnt;
               level_up_d = adv_up;
            end
            if (grace_q == '0) begin
               state_d = PLAY;
            end else if (bus.frame_tick) begin
               grace_d = grace_q - GR_W'(1);
               if (grace_q == GR_W'(1)) state_d = PLAY;
            end
         end
         OVER: begin
            if (bus.start) begin
               state_d    = PLAY;
               level_d    = '0;
               pass_cnt_d = '0;
               lives_d    = LIV_W'(LIVES);
            end
         end
         default: state_d = PLAY;
      endcase
`else
      if (bus.hit) begin
         level_d    = '0;
         pass_cnt_d = '0;
      end else if (pass) begin
         level_d    = adv_level;
         pass_cnt_d = adv_cnt;
         level_up_d = adv_up;
      end
`endif
   end

   // state and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= PLAY;
         level_q    <= '0;
         pass_cnt_q <= '0;
         lives_q    <= LIV_W'(LIVES);
         grace_q    <= '0;
         level_up_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         pass_cnt_q <= pass_cnt_d;
         lives_q    <= lives_d;
         grace_q    <= grace_d;
         level_up_q <= level_up_d;
      end
   end

   // one-hot level decode, blanked in OVER
   always_comb begin
      shapes_c = '0;
      if (state_q != OVER) shapes_c[level_q] = 1'b1;
   end

   assign bus.shapes   = shapes_c;
   assign bus.level    = level_q;
   assign bus.level_up = level_up_q;
`ifdef LEVEL_LIVES_EN
   assign bus.lives_left = lives_q;
   assign bus.game_over  = (state_q == OVER);
`else
   logic unused_inputs;
   assign unused_inputs  = bus.frame_tick ^ bus.start ^ (|lives_q);
   assign bus.lives_left = LIV_W'(LIVES);
   assign bus.game_over  = 1'b0;
`endif

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer (NUM_LEVELS=4, PASSES_PER_LEVEL=2,
// LIVES=3, GRACE_FRAMES=2). Expected outputs go into a queue when a step is
// driven and are popped and compared after the clock edge.
module tb_level_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   level_sequencer_if #(.NUM_LEVELS(4), .COUNT_W(11), .LIVES(3)) bus();

   level_sequencer #(
      .NUM_LEVELS       (4),
      .COUNT_W          (11),
      .WRAP_COUNT       (695),
      .PASSES_PER_LEVEL (2),
      .LIVES            (3),
      .GRACE_FRAMES     (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic [1:0] level;
      logic [3:0] shapes;
      logic [1:0] lives;
      logic       lu;
      logic       go;
   } exp_t;

   exp_t sbq[$];
   int   nvec    = 0;
   int   nmis    = 0;
   int   lu_cnt  = 0;
   int   lu_base = 0;

   always @(negedge clk) if (bus.level_up === 1'b1) lu_cnt++;

   task automatic check_out();
      exp_t e;
      e = sbq.pop_front();
      nvec++;
      assert (bus.level === e.level) else begin
         nmis++; $error("FAIL %s.level observed %0d expected %0d", e.tag, bus.level, e.level);
      end
      nvec++;
      assert (bus.shapes === e.shapes) else begin
         nmis++; $error("FAIL %s.shapes observed %b expected %b", e.tag, bus.shapes, e.shapes);
      end
      nvec++;
      assert (bus.lives_left === e.lives) else begin
         nmis++; $error("FAIL %s.lives observed %0d expected %0d", e.tag, bus.lives_left, e.lives);
      end
      nvec++;
      assert (bus.level_up === e.lu) else begin
         nmis++; $error("FAIL %s.level_up observed %b expected %b", e.tag, bus.level_up, e.lu);
      end
      nvec++;
      assert (bus.game_over === e.go) else begin
         nmis++; $error("FAIL %s.game_over observed %b expected %b", e.tag, bus.game_over, e.go);
      end
   endtask

   task automatic apply(input logic rs, input logic [10:0] oc, input logic h,
                        input logic ft, input logic st, input string tag,
                        input logic [1:0] lv, input logic [3:0] sh,
                        input logic [1:0] lf, input logic lu, input logic go);
      @(negedge clk);
      reset          = rs;
      bus.obj_count  = oc;
      bus.hit        = h;
      bus.frame_tick = ft;
      bus.start      = st;
      sbq.push_back('{tag, lv, sh, lf, lu, go});
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic run(input logic [10:0] oc, input logic h, input logic ft, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset          = 1'b0;
         bus.obj_count  = oc;
         bus.hit        = h;
         bus.frame_tick = ft;
         bus.start      = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic check_lu(input string tag, input int exp_pulses);
      nvec++;
      assert ((lu_cnt - lu_base) === exp_pulses) else begin
         nmis++; $error("FAIL %s observed %0d expected %0d", tag, lu_cnt - lu_base, exp_pulses);
      end
   endtask

   initial begin
      bus.obj_count  = '0;
      bus.hit        = 1'b0;
      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;

      // reset state, with a hit applied during reset
      apply(1, 0,   1, 0, 0, "reset", 2'd0, 4'b0001, 2'd3, 0, 0);
      lu_base = lu_cnt;

      // two long holds at the wrap value: one level step, one pulse
      apply(0, 695, 0, 0, 0, "pass1",   2'd0, 4'b0001, 2'd3, 0, 0);
      run(695, 0, 0, 9);
      run(0,   0, 0, 3);
      apply(0, 695, 0, 0, 0, "pass2",   2'd1, 4'b0010, 2'd3, 1, 0);
      apply(0, 695, 0, 0, 0, "p2_hold", 2'd1, 4'b0010, 2'd3, 0, 0);
      run(695, 0, 0, 8);
      run(0,   0, 0, 3);
      check_lu("lvlup_pulses", 1);

`ifdef LEVEL_LIVES_EN
      // hit coincident with a pass: hit wins, pass counter cleared
      run(695, 0, 0, 1);
      run(0,   0, 0, 1);
      apply(0, 695, 1, 0, 0, "hit_pass",   2'd1, 4'b0010, 2'd2, 0, 0);
      apply(0, 0,   1, 0, 0, "hit_grace",  2'd1, 4'b0010, 2'd2, 0, 0);
      apply(0, 0,   0, 1, 0, "tick1",      2'd1, 4'b0010, 2'd2, 0, 0);
      apply(0, 0,   0, 1, 0, "tick2",      2'd1, 4'b0010, 2'd2, 0, 0);
      apply(0, 695, 0, 0, 0, "pass_clr",   2'd1, 4'b0010, 2'd2, 0, 0);
      run(0, 0, 0, 1);
      apply(0, 0,   1, 0, 0, "hit2",       2'd1, 4'b0010, 2'd1, 0, 0);
      // passes still count inside the grace window
      apply(0, 695, 0, 0, 0, "gpass1",     2'd1, 4'b0010, 2'd1, 0, 0);
      run(0, 0, 0, 1);
      apply(0, 695, 0, 0, 0, "gpass2",     2'd2, 4'b0100, 2'd1, 1, 0);
      run(0, 0, 0, 1);
      run(0, 0, 1, 2);
      apply(0, 0,   1, 0, 0, "hit3_over",  2'd2, 4'b0000, 2'd0, 0, 1);
      apply(0, 695, 1, 1, 0, "over_ign",   2'd2, 4'b0000, 2'd0, 0, 1);
      apply(0, 0,   0, 0, 1, "start",      2'd0, 4'b0001, 2'd3, 0, 0);
      apply(0, 0,   0, 0, 1, "start_play", 2'd0, 4'b0001, 2'd3, 0, 0);

      // reset in the middle of a grace window at level 2
      for (int i = 0; i < 4; i++) begin
         run(695, 0, 0, 1);
         run(0,   0, 0, 1);
      end
      apply(0, 0,   1, 0, 0, "hit_pre_rst",  2'd2, 4'b0100, 2'd2, 0, 0);
      apply(1, 695, 1, 1, 0, "rst_grace",    2'd0, 4'b0001, 2'd3, 0, 0);
      apply(0, 0,   1, 0, 0, "hit_post_rst", 2'd0, 4'b0001, 2'd2, 0, 0);
`else
      // without lives: any hit drops back to level 0
      run(695, 0, 0, 1);
      run(0,   0, 0, 1);
      run(695, 0, 0, 1);
      run(0,   0, 0, 1);
      apply(0, 0,   0, 0, 0, "at_lvl2",   2'd2, 4'b0100, 2'd3, 0, 0);
      apply(0, 0,   1, 0, 0, "hit_lvl2",  2'd0, 4'b0001, 2'd3, 0, 0);
      apply(0, 0,   0, 1, 1, "start_ign", 2'd0, 4'b0001, 2'd3, 0, 0);
      apply(0, 695, 1, 0, 0, "hit_pass",  2'd0, 4'b0001, 2'd3, 0, 0);
      run(0, 0, 0, 1);
      apply(0, 695, 0, 0, 0, "pass_a",    2'd0, 4'b0001, 2'd3, 0, 0);
      run(0, 0, 0, 1);
      apply(0, 695, 0, 0, 0, "pass_b",    2'd1, 4'b0010, 2'd3, 1, 0);
      apply(0, 0,   1, 1, 0, "hit_again", 2'd0, 4'b0001, 2'd3, 0, 0);
`endif

      // eight passes from reset: saturate at the top level
      apply(1, 0, 0, 0, 0, "rst2", 2'd0, 4'b0001, 2'd3, 0, 0);
      lu_base = lu_cnt;
      for (int i = 0; i < 8; i++) begin
         run(695, 0, 0, 1);
         run(0,   0, 0, 1);
      end
      apply(0, 0, 0, 0, 0, "saturate", 2'd3, 4'b1000, 2'd3, 0, 0);
      check_lu("sat_pulses", 3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
